memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares one single-port memory bus between the core's instruction-fetch and data-access interfaces.
//  Sits between phoeniX and the memory model/SoC bus; latches requests, sequences one transaction at a time,
//  returns read data and drives per-port stall signals into the pipeline. Data port has priority, bounded anti-starvation.
// PARAMETERS
//  MAX_DATA_STREAK  4  consecutive data grants allowed while fetch waits; next grant forced to fetch (1..15)
//  ADDRESS_WIDTH    32 width of all address signals
// PORTS
//  clk                                     in  1  core clock; all state updates on rising edge
//  reset                                   in  1  asynchronous, active-low reset
//  instruction_memory_interface_enable     in  1  fetch request pending (held until stall low)
//  instruction_memory_interface_state      in  1  `READ/`WRITE (fetch always `READ)
//  instruction_memory_interface_address    in  32 fetch byte address
//  instruction_memory_interface_frame_mask in  4  byte mask; bit3->[7:0], bit2->[15:8], bit1->[23:16], bit0->[31:24]
//  instruction_memory_interface_data       out 32 fetched word, valid in DONE cycle, held after
//  instruction_stall                       out 1  fetch port must hold request
//  data_memory_interface_enable            in  1  data request pending (held until stall low)
//  data_memory_interface_state             in  1  `READ/`WRITE
//  data_memory_interface_address           in  32 data byte address
//  data_memory_interface_frame_mask        in  4  byte mask, same bit mapping as fetch
//  data_memory_interface_wdata             in  32 store data
//  data_memory_interface_rdata             out 32 load data, valid in DONE cycle, held after
//  data_stall                              out 1  data port must hold request
//  mem_req / mem_we                        out 1  bus request / write strobe
//  mem_address  out 32 / mem_frame_mask out 4 / mem_wdata out 32 — latched copies of granted request
//  mem_rdata                               in  32 bus read data, valid with mem_ready
//  mem_ready                               in  1  bus completes current transfer (0..N wait cycles)
//  perf_instruction_grants / perf_data_grants / perf_fetch_wait  out 32 each  counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE; mem_req, mem_we, mem_address, mem_frame_mask, mem_wdata, both *_data/rdata,
//   streak counter, perf counters = 0; mem_req drops immediately, any in-flight transfer abandoned.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: sample enables. None -> stay. Only one -> grant it. Both -> data, unless streak==MAX_DATA_STREAK -> fetch.
//    On grant: latch address/mask/state/wdata into mem_*, mem_we = (state==`WRITE); go BUSY next edge.
//   BUSY: mem_req=1, mem_* stable. mem_ready=1 -> capture mem_rdata into granted port's data reg (reads only;
//    writes leave it unchanged), mem_req=0 next cycle, go DONE.
//   DONE: one cycle; granted port's stall=0. Always returns to IDLE (requester still holds enable this cycle;
//    it must not be re-granted from it).
//  stall_x = enable_x && !(state==DONE && grant==x). Combinational from state/enable.
//  Latency: zero-wait bus -> request cycle N, mem_req N+1, DONE N+2; throughput 1 transfer / 3 cycles.
//  Streak counter: +1 per data grant while fetch enable high (saturates at MAX_DATA_STREAK); clears on fetch grant
//   or when fetch enable low in IDLE.
//  Requester drops enable during BUSY: bus transfer completes, data register NOT updated, DONE still taken.
//  mem_ready outside BUSY: ignored. Address passed unmodified (memory aligns by >>2).
// CONFIGURATION
//  MEMORY_ARBITER_PERF_EN defined: three 32-bit saturating counters: grants per port (+1 in IDLE on grant),
//   perf_fetch_wait +1 each cycle instruction_stall==1. Saturate at 32'hFFFF_FFFF; cleared only by reset.
//  Undefined: counter logic absent, perf_* outputs tied to 32'h0. Port list unchanged in both builds.
// STRUCTURE
//  Shared defines file: `READ/`WRITE, `ENABLE/`DISABLE, FSM encodings ARB_IDLE/ARB_BUSY/ARB_DONE, grant
//   encodings GRANT_INSTRUCTION/GRANT_DATA.
//  One sub-module: memory_arbiter_grant_select (combinational priority + streak override, returns grant id).
//  FSM, latches, counters stay in top.
// TESTING
//  Fetch only, addr 0x40, mem_ready same cycle as mem_req, rdata 0x00000013 -> instruction_data=0x13 in DONE,
//   stall low exactly that cycle, mem_req high exactly 1 cycle.
//  Simultaneous fetch 0x100 + data store 0x2000 mask 4'b1111 wdata 0xDEADBEEF -> data granted first with mem_we=1,
//   fetch granted on next IDLE; fetch stall high 6 cycles total.
//  Data enable held high continuously, fetch pending, MAX_DATA_STREAK=4 -> exactly 4 data grants then 1 fetch grant.
//  mem_ready delayed 5 cycles -> mem_* stable throughout BUSY, stall high until DONE, no second mem_req.
//  reset pulled low during BUSY -> mem_req low immediately, outputs zero; after release a new fetch completes normally.
//  MEMORY_ARBITER_PERF_EN build, run scenario 2 -> perf_instruction_grants=1, perf_data_grants=1,
//   perf_fetch_wait=6; undefined build -> all perf_* = 0.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter:
// access direction, enable levels, FSM state and grant encodings.
package memory_arbiter_pkg;

  localparam logic READ    = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_INSTRUCTION = 1'b0,
    GRANT_DATA        = 1'b1
  } grant_t;

  // Wide enough for streak limits 1..15.
  localparam int STREAK_WIDTH  = 4;
  localparam int PERF_COUNTERS = 3;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic inc);
    return (inc && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/memory_arbiter_grant_select.sv
// Combinational grant choice: data wins over fetch unless the data port has
// already taken MAX_DATA_STREAK grants in a row while fetch was waiting.
module memory_arbiter_grant_select
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic                    instr_req,
  input  logic                    data_req,
  input  logic [STREAK_WIDTH-1:0] streak,
  output logic                    grant_valid,
  output grant_t                  grant
);

  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = MAX_DATA_STREAK[STREAK_WIDTH-1:0];

  always_comb begin
    grant_valid = instr_req | data_req;
    grant       = GRANT_DATA;
    if (instr_req && (!data_req || (streak >= STREAK_MAX))) begin
      grant = GRANT_INSTRUCTION;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Single-port memory bus arbiter between instruction fetch and data access.
// Optional performance counters are built when MEMORY_ARBITER_PERF_EN is defined.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDRESS_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     instruction_memory_interface_enable,
  input  logic                     instruction_memory_interface_state,
  input  logic [ADDRESS_WIDTH-1:0] instruction_memory_interface_address,
  input  logic [3:0]               instruction_memory_interface_frame_mask,
  output logic [31:0]              instruction_memory_interface_data,
  output logic                     instruction_stall,

  input  logic                     data_memory_interface_enable,
  input  logic                     data_memory_interface_state,
  input  logic [ADDRESS_WIDTH-1:0] data_memory_interface_address,
  input  logic [3:0]               data_memory_interface_frame_mask,
  input  logic [31:0]              data_memory_interface_wdata,
  output logic [31:0]              data_memory_interface_rdata,
  output logic                     data_stall,

  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [3:0]               mem_frame_mask,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ready,

  output logic [31:0]              perf_instruction_grants,
  output logic [31:0]              perf_data_grants,
  output logic [31:0]              perf_fetch_wait
);

  localparam logic [STREAK_WIDTH-1:0] STREAK_MAX = MAX_DATA_STREAK[STREAK_WIDTH-1:0];

  arb_state_t               state_reg, state_next;
  grant_t                   grant_reg;
  grant_t                   sel_grant;
  logic                     sel_valid;
  logic [STREAK_WIDTH-1:0]  streak_reg, streak_next;

  logic                     mem_req_reg, mem_we_reg;
  logic [ADDRESS_WIDTH-1:0] mem_address_reg;
  logic [3:0]               mem_frame_mask_reg;
  logic [31:0]              mem_wdata_reg;

  logic                     grant_fire;
  logic                     transfer_done;
  logic                     read_done;
  logic [1:0]               port_en;

  assign port_en = {data_memory_interface_enable, instruction_memory_interface_enable};

  memory_arbiter_grant_select #(
    .MAX_DATA_STREAK (MAX_DATA_STREAK)
  ) u_grant_select (
    .instr_req   (instruction_memory_interface_enable),
    .data_req    (data_memory_interface_enable),
    .streak      (streak_reg),
    .grant_valid (sel_valid),
    .grant       (sel_grant)
  );

  assign grant_fire    = (state_reg == ARB_IDLE) && sel_valid;
  assign transfer_done = (state_reg == ARB_BUSY) && mem_ready;
  assign read_done     = transfer_done && !mem_we_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (sel_valid) state_next = ARB_BUSY;
      ARB_BUSY: if (mem_ready) state_next = ARB_DONE;
      ARB_DONE: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // A port is released only in the DONE cycle of its own transfer.
  always_comb begin
    instruction_stall = instruction_memory_interface_enable &&
                        !((state_reg == ARB_DONE) && (grant_reg == GRANT_INSTRUCTION));
    data_stall        = data_memory_interface_enable &&
                        !((state_reg == ARB_DONE) && (grant_reg == GRANT_DATA));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_reg          <= GRANT_INSTRUCTION;
      mem_req_reg        <= 1'b0;
      mem_we_reg         <= 1'b0;
      mem_address_reg    <= '0;
      mem_frame_mask_reg <= '0;
      mem_wdata_reg      <= '0;
    end else if (grant_fire) begin
      grant_reg   <= sel_grant;
      mem_req_reg <= 1'b1;
      if (sel_grant == GRANT_DATA) begin
        mem_we_reg         <= (data_memory_interface_state == WRITE);
        mem_address_reg    <= data_memory_interface_address;
        mem_frame_mask_reg <= data_memory_interface_frame_mask;
        mem_wdata_reg      <= data_memory_interface_wdata;
      end else begin
        mem_we_reg         <= (instruction_memory_interface_state == WRITE);
        mem_address_reg    <= instruction_memory_interface_address;
        mem_frame_mask_reg <= instruction_memory_interface_frame_mask;
        mem_wdata_reg      <= '0;
      end
    end else if (transfer_done) begin
      mem_req_reg <= 1'b0;
      mem_we_reg  <= 1'b0;
    end
  end

  assign mem_req        = mem_req_reg;
  assign mem_we         = mem_we_reg;
  assign mem_address    = mem_address_reg;
  assign mem_frame_mask = mem_frame_mask_reg;
  assign mem_wdata      = mem_wdata_reg;

  // Read data lands only if the owning requester is still asking for it.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam grant_t PORT_ID = (gi == 0) ? GRANT_INSTRUCTION : GRANT_DATA;
      logic [31:0] port_data_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          port_data_reg <= '0;
        end else if (read_done && (grant_reg == PORT_ID) && port_en[gi]) begin
          port_data_reg <= mem_rdata;
        end
      end
    end
  endgenerate

  assign instruction_memory_interface_data = g_port[0].port_data_reg;
  assign data_memory_interface_rdata       = g_port[1].port_data_reg;

  // Streak counts data grants taken while fetch is waiting; any idle cycle
  // without a fetch request forgets the history.
  always_comb begin
    streak_next = streak_reg;
    if (state_reg == ARB_IDLE) begin
      if (!instruction_memory_interface_enable) begin
        streak_next = '0;
      end else if (sel_valid && (sel_grant == GRANT_INSTRUCTION)) begin
        streak_next = '0;
      end else if (sel_valid && (streak_reg != STREAK_MAX)) begin
        streak_next = streak_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_reg <= '0;
    end else begin
      streak_reg <= streak_next;
    end
  end

`ifdef MEMORY_ARBITER_PERF_EN
  logic [PERF_COUNTERS-1:0] perf_inc;

  assign perf_inc[0] = grant_fire && (sel_grant == GRANT_INSTRUCTION);
  assign perf_inc[1] = grant_fire && (sel_grant == GRANT_DATA);
  assign perf_inc[2] = instruction_stall;

  generate
    for (gi = 0; gi < PERF_COUNTERS; gi++) begin : g_perf
      logic [31:0] cnt_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= sat_inc32(cnt_reg, perf_inc[gi]);
        end
      end
    end
  endgenerate

  assign perf_instruction_grants = g_perf[0].cnt_reg;
  assign perf_data_grants        = g_perf[1].cnt_reg;
  assign perf_fetch_wait         = g_perf[2].cnt_reg;
`else
  assign perf_instruction_grants = 32'h0;
  assign perf_data_grants        = 32'h0;
  assign perf_fetch_wait         = 32'h0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ien, ist, den, dst;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  imask, dmask;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  logic [31:0] idata, drdata, mem_address, mem_wdata;
  logic [31:0] perf_ig, perf_dg, perf_fw;
  logic [3:0]  mem_frame_mask;
  logic        istall, dstall, mem_req, mem_we;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  memory_arbiter #(
    .MAX_DATA_STREAK (MAX),
    .ADDRESS_WIDTH   (32)
  ) dut (
    .clk                                     (clk),
    .reset                                   (reset),
    .instruction_memory_interface_enable     (ien),
    .instruction_memory_interface_state      (ist),
    .instruction_memory_interface_address    (iaddr),
    .instruction_memory_interface_frame_mask (imask),
    .instruction_memory_interface_data       (idata),
    .instruction_stall                       (istall),
    .data_memory_interface_enable            (den),
    .data_memory_interface_state             (dst),
    .data_memory_interface_address           (daddr),
    .data_memory_interface_frame_mask        (dmask),
    .data_memory_interface_wdata             (dwdata),
    .data_memory_interface_rdata             (drdata),
    .data_stall                              (dstall),
    .mem_req                                 (mem_req),
    .mem_we                                  (mem_we),
    .mem_address                             (mem_address),
    .mem_frame_mask                          (mem_frame_mask),
    .mem_wdata                               (mem_wdata),
    .mem_rdata                               (mem_rdata),
    .mem_ready                               (mem_ready),
    .perf_instruction_grants                 (perf_ig),
    .perf_data_grants                        (perf_dg),
    .perf_fetch_wait                         (perf_fw)
  );

  // Reference model: which port owns the bus slot and in which phase of the
  // transfer it is (0 = free, 1 = on the bus, 2 = handing back), plus the
  // request copy, port data, streak and counters.
  int          m_phase, m_owner, m_streak;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_idata, m_drdata, m_ig, m_dg, m_fw;
  logic [3:0]  m_mask;

  function automatic int pick_port();
    return (den && !(ien && (m_streak >= MAX))) ? 1 : 0;
  endfunction

  function automatic logic [31:0] inc_sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic exp_istall();
    return ien && !((m_phase == 2) && (m_owner == 0));
  endfunction

  function automatic logic exp_dstall();
    return den && !((m_phase == 2) && (m_owner == 1));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase <= 0; m_owner <= 0; m_streak <= 0; m_we <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_mask <= '0; m_idata <= '0; m_drdata <= '0;
      m_ig <= '0; m_dg <= '0; m_fw <= '0;
    end else begin
      if (exp_istall()) m_fw <= inc_sat(m_fw);
      if (m_phase == 0) begin
        if (ien || den) begin
          m_owner <= pick_port();
          m_phase <= 1;
          if (pick_port() == 1) begin
            m_we <= (dst == WRITE); m_addr <= daddr; m_mask <= dmask; m_wdata <= dwdata;
            m_dg <= inc_sat(m_dg);
          end else begin
            m_we <= (ist == WRITE); m_addr <= iaddr; m_mask <= imask; m_wdata <= '0;
            m_ig <= inc_sat(m_ig);
          end
        end
        if (!ien || pick_port() == 0) m_streak <= 0;
        else m_streak <= (m_streak < MAX) ? m_streak + 1 : MAX;
      end else if (m_phase == 1) begin
        if (mem_ready) begin
          m_phase <= 2;
          if (!m_we && m_owner == 1 && den) m_drdata <= mem_rdata;
          if (!m_we && m_owner == 0 && ien) m_idata <= mem_rdata;
        end
      end else begin
        m_phase <= 0;
      end
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic model_compare();
    chk1("mem_req", mem_req, m_phase == 1);
    if (m_phase == 1) begin
      chk1 ("mem_we", mem_we, m_we);
      chk32("mem_address", mem_address, m_addr);
      chk32("mem_frame_mask", {28'b0, mem_frame_mask}, {28'b0, m_mask});
      chk32("mem_wdata", mem_wdata, m_wdata);
    end
    chk1 ("instruction_stall", istall, exp_istall());
    chk1 ("data_stall", dstall, exp_dstall());
    chk32("instruction_data", idata, m_idata);
    chk32("data_rdata", drdata, m_drdata);
`ifdef MEMORY_ARBITER_PERF_EN
    chk32("perf_instruction_grants", perf_ig, m_ig);
    chk32("perf_data_grants", perf_dg, m_dg);
    chk32("perf_fetch_wait", perf_fw, m_fw);
`else
    chk32("perf_instruction_grants", perf_ig, 32'h0);
    chk32("perf_data_grants", perf_dg, 32'h0);
    chk32("perf_fetch_wait", perf_fw, 32'h0);
`endif
    if (m_phase == 2)
      $display("txn %s %s addr=%08h mask=%h", (m_owner == 1) ? "data " : "fetch",
               m_we ? "write" : "read ", m_addr, m_mask);
  endtask

  // Sample mid-cycle on the falling edge, drive just after the rising edge.
  task automatic mid();
    @(negedge clk);
    model_compare();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  int  req_cycles, stall_cycles;
  int  gseq[$];
  int  exp_seq[5] = '{1, 1, 1, 1, 0};
  logic fetch_done, i_done, d_done;

  initial begin
    reset = 1'b0; ien = 1'b0; ist = READ; iaddr = '0; imask = '0;
    den = 1'b0; dst = READ; daddr = '0; dmask = '0; dwdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    adv(); adv();
    mid();
    chk1 ("reset mem_req", mem_req, 1'b0);
    chk32("reset mem_address", mem_address, 32'h0);
    chk32("reset instruction_data", idata, 32'h0);
    chk32("reset perf_fetch_wait", perf_fw, 32'h0);
    adv();
    reset = 1'b1;
    mid(); adv();

    // Fetch 0x100 and store 0x2000 together; the bus answers the fetch read
    // with one wait state, so fetch stalls through cycles 0..5.
    ien = 1'b1; ist = READ; iaddr = 32'h100; imask = 4'hF;
    den = 1'b1; dst = WRITE; daddr = 32'h2000; dmask = 4'hF; dwdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1111_2222;
    stall_cycles = 0;
    for (int c = 0; c < 7; c++) begin
      if (c >= 3) den = 1'b0;
      mem_ready = (c != 4);
      mid();
      if (istall) stall_cycles++;
      case (c)
        0: chk1("s2 c0 mem_req", mem_req, 1'b0);
        1: begin
          chk1 ("s2 data mem_we", mem_we, 1'b1);
          chk32("s2 data address", mem_address, 32'h2000);
          chk32("s2 data wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        2: begin
          chk1("s2 data released", dstall, 1'b0);
          chk1("s2 fetch held", istall, 1'b1);
        end
        4: begin
          chk32("s2 fetch address", mem_address, 32'h100);
          chk1 ("s2 fetch mem_we", mem_we, 1'b0);
        end
        6: begin
          chk1 ("s2 fetch released", istall, 1'b0);
          chk32("s2 fetch data", idata, 32'h1111_2222);
`ifdef MEMORY_ARBITER_PERF_EN
          chk32("s2 perf_instruction_grants", perf_ig, 32'd1);
          chk32("s2 perf_data_grants", perf_dg, 32'd1);
          chk32("s2 perf_fetch_wait", perf_fw, 32'd6);
`else
          chk32("s2 perf_fetch_wait off", perf_fw, 32'd0);
`endif
        end
        default: ;
      endcase
      adv();
    end
    ien = 1'b0;
    chk32("s2 fetch stall cycles", stall_cycles, 32'd6);

    // Lone fetch of 0x40 with a zero-wait bus.
    iaddr = 32'h40; mem_rdata = 32'h0000_0013; mem_ready = 1'b1;
    req_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      ien = (c != 3);
      mid();
      if (mem_req) req_cycles++;
      if (c == 1) chk32("s1 address", mem_address, 32'h40);
      if (c < 2)  chk1 ("s1 stall held", istall, 1'b1);
      if (c == 2) begin
        chk32("s1 instruction_data", idata, 32'h13);
        chk1 ("s1 stall released", istall, 1'b0);
      end
      adv();
    end
    chk32("s1 mem_req cycles", req_cycles, 32'd1);

    // Reset in the middle of a transfer abandons it immediately.
    ien = 1'b1; iaddr = 32'h48; mem_ready = 1'b0;
    mid(); adv();
    mid();
    chk1("s5 busy before reset", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk1 ("s5 mem_req dropped", mem_req, 1'b0);
    chk32("s5 address cleared", mem_address, 32'h0);
    chk32("s5 instruction_data cleared", idata, 32'h0);
    adv();
    reset = 1'b1; ien = 1'b0;
    mid(); adv();
    ien = 1'b1; iaddr = 32'h80; mem_rdata = 32'hCAFE_F00D; mem_ready = 1'b1;
    mid(); adv(); mid(); adv(); mid();
    chk32("s5 fetch after reset", idata, 32'hCAFE_F00D);
    adv();
    ien = 1'b0;

    // Data read with five wait states.
    den = 1'b1; dst = READ; daddr = 32'h1234_5678; dmask = 4'b0011; mem_rdata = 32'hA5A5_0F0F;
    req_cycles = 0;
    for (int c = 0; c < 9; c++) begin
      mem_ready = (c == 6);
      if (c == 8) den = 1'b0;
      mid();
      if (mem_req) req_cycles++;
      if (c >= 1 && c <= 6) begin
        chk32("s4 address stable", mem_address, 32'h1234_5678);
        chk1 ("s4 stall held", dstall, 1'b1);
      end
      if (c == 7) begin
        chk1 ("s4 stall released", dstall, 1'b0);
        chk32("s4 rdata", drdata, 32'hA5A5_0F0F);
      end
      adv();
    end
    chk32("s4 mem_req cycles", req_cycles, 32'd6);

    // Data requests back to back while fetch waits: streak limit forces fetch.
    ien = 1'b1; iaddr = 32'h500; den = 1'b1; dst = READ; daddr = 32'h3000; mem_ready = 1'b1;
    fetch_done = 1'b0;
    for (int c = 0; c < 60 && !fetch_done; c++) begin
      mem_rdata = $urandom;
      mid();
      if (mem_req) gseq.push_back((mem_address == 32'h500) ? 0 : 1);
      if (ien && !istall) fetch_done = 1'b1;
      adv();
    end
    ien = 1'b0; den = 1'b0;
    chk1 ("s3 fetch served", fetch_done, 1'b1);
    chk32("s3 grant count", gseq.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < gseq.size()) chk32($sformatf("s3 grant %0d", i), gseq[i], exp_seq[i]);

    // Randomized traffic, including occasional requesters abandoning a transfer.
    i_done = 1'b0; d_done = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (!ien || i_done) begin
        ien = ($urandom_range(0, 2) != 0); ist = READ;
        iaddr = $urandom & 32'hFFFF_FFFC; imask = 4'hF;
      end else if (m_phase == 1 && m_owner == 0 && $urandom_range(0, 15) == 0) begin
        ien = 1'b0;
      end
      if (!den || d_done) begin
        den = ($urandom_range(0, 1) == 1); dst = 1'($urandom_range(0, 1));
        daddr = $urandom; dmask = 4'($urandom_range(0, 15)); dwdata = $urandom;
      end else if (m_phase == 1 && m_owner == 1 && $urandom_range(0, 15) == 0) begin
        den = 1'b0;
      end
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      mid();
      i_done = ien && (m_phase == 2) && (m_owner == 0);
      d_done = den && (m_phase == 2) && (m_owner == 1);
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
